cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Mode-1 control unit that sequences the program-counter/ROM datapath. It fetches each instruction, decodes it and dispatches it to the ALU over a start/done handshake, then writes the result back to an 8-bit accumulator.
- It owns the PC enable: the PC advances exactly once per fetched instruction.
- Sits between the PC/ROM block and the ALU, under top-level run/step control.

Parameters:
- ALU_TIMEOUT, 15, max cycles to wait for alu_done after alu_start before flagging error (1..255).
- STEP_MODE_DEFAULT, 0, reserved; must be 0.

Ports:
- clock  in  1  system clock; sole clock.
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- ena  in  1  global enable; when 0 all state and registers hold, and outputs hold except pc_ena/alu_start, which are forced 0.
- run  in  1  level: 1 = free-run, 0 = stop after the current instruction retires.
- step  in  1  single-cycle pulse: from IDLE, execute exactly one instruction.
- instr_in  in  8  instruction from PC/ROM, combinational on current PC; [7:5] opcode, [4:0] operand.
- pc_ena  out  1  one-cycle pulse that advances the PC.
- alu_start  out  1  one-cycle pulse launching an ALU op.
- alu_op  out  3  opcode to ALU, held from EXEC until WB.
- alu_a  out  8  = acc, held from EXEC until WB.
- alu_b  out  8  = {3'b000, operand}, held from EXEC until WB.
- alu_result  in  8  ALU result, sampled when alu_done=1.
- alu_done  in  1  ALU completion; may arrive 1..N cycles after alu_start.
- acc_out  out  8  accumulator.
- instr_count  out  8  retired-instruction counter; wraps 255->0.
- state_out  out  3  FSM state encoding, for debug.
- busy  out  1  1 in any state other than IDLE or HALT.
- halted  out  1  1 in HALT.
- error  out  1  sticky ALU-timeout flag.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; acc, ir, instr_count, timeout counter=0; every output 0.
- State encoding: IDLE=0, FETCH=1, EXEC=2, WAIT=3, WB=4, HALT=5.
- IDLE: go to FETCH if run=1 or step=1. Record step-mode = (run==0).
- FETCH (1 cycle):
  - ir <= instr_in; pc_ena=1 this cycle.
  - Opcode 111 (HALT) goes to HALT. Opcode 110 (LDI) goes to WB. All others go to EXEC.
- EXEC (1 cycle): alu_start=1; alu_op/alu_a/alu_b driven; timeout counter cleared; go to WAIT.
- WAIT:
  - alu_done=1 -> latch alu_result and go to WB.
  - Otherwise the counter increments. When the counter reaches ALU_TIMEOUT: error<=1, go to HALT, acc unchanged.
  - alu_done arriving in the same cycle as the alu_start pulse is ignored; done is only sampled in WAIT.
- WB (1 cycle):
  - acc <= latched result, or {3'b0,operand} for LDI.
  - instr_count increments.
  - Next state: FETCH if run=1 and not in step mode; otherwise IDLE.
- HALT:
  - HALT is retired: instr_count increments on entry, PC has advanced.
  - Remains in HALT until reset. run/step are ignored.
- ALU opcodes: 000 ADD, 001 SUB, 010 MUL, 011 AND, 100 OR, 101 XOR.
  - All results are 8-bit, truncated by the ALU; the sequencer does no arithmetic.
  - 0x00 (ADD 0) is the NOP and runs the full EXEC/WAIT/WB path.
- Minimum instruction latency: 4 cycles for ALU ops (FETCH, EXEC, WAIT with done, WB); 2 cycles for LDI.
- run dropping mid-instruction: the current instruction completes, then IDLE.
- step while busy: ignored.
- step and run both 1 in IDLE: treated as free-run.
- ena=0 during WAIT: the timeout counter freezes and alu_done is not sampled.
- reset_n asserted mid-operation: immediate return to reset values; no partial writeback.

Test Plan:
1. Program ROM {0x03, 0x22, 0x45, 0x00}, mock ALU done latency 1 (ADD/SUB) and 3 (MUL), run=1 → acc 3, 1, 5, 5; instr_count 4 after the NOP; 4 pc_ena pulses; then the loop repeats with acc 8.
2. run=0, step pulse with ROM[0]=0x03 → exactly one pc_ena, acc=3, instr_count=1, returns to IDLE (state_out=0); a second step gives acc=6.
3. ROM[0]=0xC7 (LDI 7), ROM[1]=0xE0 (HALT) → acc=7 two cycles after FETCH; halted=1, busy=0, instr_count=2, no further pc_ena.
4. Mock ALU never asserts done → error=1 and halted=1 exactly ALU_TIMEOUT=15 cycles after WAIT entry; acc unchanged.
5. Assert reset_n=0 during WAIT, then release → all outputs 0, state IDLE; alu_done pulsed afterwards has no effect.
6. 256 retired NOPs in free-run → instr_count wraps to 0; hold ena=0 for 5 cycles mid-WAIT → no timeout and no state change.

Source files
------------

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/dispatch control unit between PC/ROM and ALU.
// Owns the PC advance, the ALU start/done handshake and the accumulator.
module cpu_sequencer #(
   parameter int ALU_TIMEOUT       = 15,
   parameter int STEP_MODE_DEFAULT = 0
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       ena,
   input  logic       run,
   input  logic       step,
   input  logic [7:0] instr_in,
   output logic       pc_ena,
   output logic       alu_start,
   output logic [2:0] alu_op,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   input  logic [7:0] alu_result,
   input  logic       alu_done,
   output logic [7:0] acc_out,
   output logic [7:0] instr_count,
   output logic [2:0] state_out,
   output logic       busy,
   output logic       halted,
   output logic       error
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      EXEC  = 3'd2,
      WAIT  = 3'd3,
      WB    = 3'd4,
      HALT  = 3'd5
   } state_t;

   localparam logic [2:0] OP_LDI    = 3'b110;
   localparam logic [2:0] OP_HALT   = 3'b111;
   localparam logic [7:0] TCNT_LAST = 8'(ALU_TIMEOUT - 1);

   state_t     state;
   state_t     state_d;
   logic [7:0] ir;
   logic [7:0] acc;
   logic [7:0] res;
   logic [7:0] cnt;
   logic [7:0] tcnt;
   logic       step_mode;
   logic [2:0] fetch_op;
   logic       timeout;
   logic       in_op;

   assign fetch_op = instr_in[7:5];
   assign timeout  = (tcnt == TCNT_LAST);
   assign in_op    = (state == EXEC) || (state == WAIT) || (state == WB);

   // ALU operands are pure views of ir/acc, so they hold through WAIT
   assign alu_op      = in_op ? ir[7:5] : 3'b000;
   assign alu_a       = in_op ? acc : 8'h00;
   assign alu_b       = in_op ? {3'b000, ir[4:0]} : 8'h00;
   assign acc_out     = acc;
   assign instr_count = cnt;
   assign state_out   = state;
   assign busy        = (state != IDLE) && (state != HALT);
   assign halted      = (state == HALT);

   always_comb begin
      state_d   = state;
      pc_ena    = 1'b0;
      alu_start = 1'b0;
      if (ena) begin
         unique case (state)
            IDLE: begin
               if (run || step)
                  state_d = FETCH;
            end
            FETCH: begin
               pc_ena = 1'b1;
               unique case (1'b1)
                  fetch_op == OP_HALT: state_d = HALT;
                  fetch_op == OP_LDI:  state_d = WB;
                  default:             state_d = EXEC;
               endcase
            end
            EXEC: begin
               alu_start = 1'b1;
               state_d   = WAIT;
            end
            WAIT: begin
               if (alu_done)
                  state_d = WB;
               else if (timeout)
                  state_d = HALT;
            end
            WB: begin
               if (run && !step_mode)
                  state_d = FETCH;
               else
                  state_d = IDLE;
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_d;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ir        <= 8'h00;
         acc       <= 8'h00;
         res       <= 8'h00;
         cnt       <= 8'h00;
         tcnt      <= 8'h00;
         step_mode <= (STEP_MODE_DEFAULT != 0);
         error     <= 1'b0;
      end else if (ena) begin
         unique case (state)
            IDLE: begin
               if (run || step)
                  step_mode <= !run;
            end
            FETCH: begin
               ir <= instr_in;
               // HALT retires on entry; it never reaches WB
               if (fetch_op == OP_HALT)
                  cnt <= cnt + 8'd1;
            end
            EXEC: tcnt <= 8'h00;
            WAIT: begin
               if (alu_done)
                  res <= alu_result;
               else if (timeout)
                  error <= 1'b1;
               else
                  tcnt <= tcnt + 8'd1;
            end
            WB: begin
               if (ir[7:5] == OP_LDI)
                  acc <= {3'b000, ir[4:0]};
               else
                  acc <= res;
               cnt <= cnt + 8'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed and random checks of cpu_sequencer against
// a ROM, a mock ALU with programmable latency and an instruction-level model.
module tb_cpu_sequencer;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       ena;
   logic       run;
   logic       step;
   logic [7:0] instr_in;
   logic       pc_ena;
   logic       alu_start;
   logic [2:0] alu_op;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [7:0] alu_result;
   logic       alu_done;
   logic [7:0] acc_out;
   logic [7:0] instr_count;
   logic [2:0] state_out;
   logic       busy;
   logic       halted;
   logic       error;

   logic       mock_done;
   logic       force_done;
   logic [7:0] mock_res;
   logic [7:0] rom [16];
   int         romlen = 1;
   int         pc = 0;
   int         lat_tab [8];
   bit         lat_rand;
   int         lat_q [$];
   int         errors = 0;
   int         checks = 0;

   always #5 clock = ~clock;

   cpu_sequencer #(.ALU_TIMEOUT(15), .STEP_MODE_DEFAULT(0)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .ena         (ena),
      .run         (run),
      .step        (step),
      .instr_in    (instr_in),
      .pc_ena      (pc_ena),
      .alu_start   (alu_start),
      .alu_op      (alu_op),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_result  (alu_result),
      .alu_done    (alu_done),
      .acc_out     (acc_out),
      .instr_count (instr_count),
      .state_out   (state_out),
      .busy        (busy),
      .halted      (halted),
      .error       (error)
   );

   assign alu_done   = mock_done | force_done;
   assign alu_result = mock_res;
   assign instr_in   = rom[4'(pc % romlen)];

   // PC/ROM environment: counts every pc_ena pulse since reset
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         pc <= 0;
      else if (pc_ena)
         pc <= pc + 1;
   end

   function automatic logic [7:0] alu_fn(input logic [2:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
      int r;
      case (op)
         3'd0:    r = a + b;
         3'd1:    r = a - b;
         3'd2:    r = a * b;
         3'd3:    r = a & b;
         3'd4:    r = a | b;
         3'd5:    r = a ^ b;
         default: r = 0;
      endcase
      return 8'(r);
   endfunction

   function automatic logic [7:0] model(input logic [7:0] acc,
                                        input logic [7:0] ins);
      if (ins[7:5] == 3'b110)
         return {3'b000, ins[4:0]};
      return alu_fn(ins[7:5], acc, {3'b000, ins[4:0]});
   endfunction

   // mock ALU: latency 0 in the table means it never answers
   initial begin
      int cnt;
      int l;
      logic [7:0] hold;
      cnt = 0;
      hold = 8'h00;
      mock_done = 1'b0;
      mock_res = 8'h00;
      forever begin
         @(negedge clock);
         mock_done = 1'b0;
         if (!reset_n) begin
            cnt = 0;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               mock_done = 1'b1;
               mock_res = hold;
            end
         end
         if (reset_n && alu_start) begin
            l = lat_rand ? int'($urandom_range(1, 4)) : lat_tab[alu_op];
            lat_q.push_back(l);
            hold = alu_fn(alu_op, alu_a, alu_b);
            cnt = l;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      run = 1'b0;
      step = 1'b0;
      ena = 1'b1;
      force_done = 1'b0;
      lat_rand = 1'b0;
      lat_q.delete();
      for (int i = 0; i < 8; i++) lat_tab[i] = 1;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic wait_retire(output int n);
      logic [7:0] prev;
      prev = instr_count;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (instr_count == prev && n < 200);
      if (n >= 200) check("retire_timeout", 64'(n), 64'd0);
   endtask

   task automatic wait_state(input logic [2:0] s);
      int n;
      n = 0;
      while (state_out !== s && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (n >= 200) check("state_timeout", 64'(state_out), 64'(s));
   endtask

   initial begin
      int n;
      logic [7:0] exp_acc;
      logic [7:0] ins;
      int exp_lat;

      reset_n = 1'b0;
      ena = 1'b1;
      run = 1'b0;
      step = 1'b0;
      force_done = 1'b0;
      lat_rand = 1'b0;
      for (int i = 0; i < 8; i++) lat_tab[i] = 1;
      for (int i = 0; i < 16; i++) rom[i] = 8'h00;
      #1;
      check("rst_ctl", 64'({pc_ena, alu_start, alu_op, state_out,
                            busy, halted, error}), 64'd0);
      check("rst_data", 64'({alu_a, alu_b, acc_out, instr_count}), 64'd0);

      // free-run program with ADD/SUB latency 1, MUL latency 3
      do_reset();
      romlen = 4;
      rom[0] = 8'h03; rom[1] = 8'h22; rom[2] = 8'h45; rom[3] = 8'h00;
      lat_tab[2] = 3;
      run = 1'b1;
      wait_retire(n);
      check("t1_acc_add", 64'(acc_out), 64'd3);
      wait_retire(n);
      check("t1_acc_sub", 64'(acc_out), 64'd1);
      check("t1_lat_sub", 64'(n), 64'd4);
      wait_retire(n);
      check("t1_acc_mul", 64'(acc_out), 64'd5);
      check("t1_lat_mul", 64'(n), 64'd6);
      wait_retire(n);
      check("t1_acc_nop", 64'(acc_out), 64'd5);
      check("t1_lat_nop", 64'(n), 64'd4);
      check("t1_count", 64'(instr_count), 64'd4);
      check("t1_pc", 64'(pc), 64'd4);
      wait_retire(n);
      check("t1_acc_loop", 64'(acc_out), 64'd8);
      run = 1'b0;

      // single step from IDLE
      do_reset();
      romlen = 1;
      rom[0] = 8'h03;
      @(negedge clock);
      step = 1'b1;
      @(negedge clock);
      step = 1'b0;
      wait_retire(n);
      repeat (3) @(negedge clock);
      check("t2_state", 64'(state_out), 64'd0);
      check("t2_pc", 64'(pc), 64'd1);
      check("t2_acc", 64'(acc_out), 64'd3);
      check("t2_count", 64'(instr_count), 64'd1);
      step = 1'b1;
      @(negedge clock);
      step = 1'b0;
      wait_retire(n);
      repeat (3) @(negedge clock);
      check("t2_acc2", 64'(acc_out), 64'd6);
      check("t2_pc2", 64'(pc), 64'd2);

      // LDI then HALT
      do_reset();
      romlen = 2;
      rom[0] = 8'hC7; rom[1] = 8'hE0;
      run = 1'b1;
      n = 0;
      while (!pc_ena && n < 20) begin
         @(negedge clock);
         n++;
      end
      check("t3_fetch_seen", 64'(pc_ena), 64'd1);
      repeat (2) @(negedge clock);
      check("t3_acc_ldi", 64'(acc_out), 64'd7);
      wait_state(3'd5);
      check("t3_halted", 64'(halted), 64'd1);
      check("t3_busy", 64'(busy), 64'd0);
      check("t3_count", 64'(instr_count), 64'd2);
      repeat (5) @(negedge clock);
      check("t3_pc", 64'(pc), 64'd2);
      check("t3_state", 64'(state_out), 64'd5);

      // ALU never answers: timeout
      do_reset();
      romlen = 1;
      rom[0] = 8'h03;
      lat_tab[0] = 0;
      run = 1'b1;
      wait_state(3'd3);
      n = 0;
      while (!halted && n < 40) begin
         @(negedge clock);
         n++;
      end
      check("t4_to_cycles", 64'(n), 64'd15);
      check("t4_error", 64'(error), 64'd1);
      check("t4_acc", 64'(acc_out), 64'd0);
      check("t4_count", 64'(instr_count), 64'd0);

      // async reset during WAIT
      do_reset();
      romlen = 2;
      rom[0] = 8'hC5; rom[1] = 8'h03;
      lat_tab[0] = 0;
      run = 1'b1;
      wait_state(3'd3);
      repeat (3) @(negedge clock);
      check("t5_acc_pre", 64'(acc_out), 64'd5);
      #2 reset_n = 1'b0;
      #1;
      check("t5_rst_ctl", 64'({pc_ena, alu_start, alu_op, state_out,
                               busy, halted, error}), 64'd0);
      check("t5_rst_data", 64'({alu_a, alu_b, acc_out, instr_count}), 64'd0);
      @(negedge clock);
      run = 1'b0;
      reset_n = 1'b1;
      force_done = 1'b1;
      @(negedge clock);
      force_done = 1'b0;
      repeat (3) @(negedge clock);
      check("t5_state", 64'(state_out), 64'd0);
      check("t5_acc", 64'(acc_out), 64'd0);
      check("t5_count", 64'(instr_count), 64'd0);
      check("t5_pc", 64'(pc), 64'd0);

      // 256 NOPs wrap the retire counter
      do_reset();
      romlen = 1;
      rom[0] = 8'h00;
      run = 1'b1;
      for (int i = 0; i < 256; i++) begin
         wait_retire(n);
         check("t6_count", 64'(instr_count), 64'((i + 1) % 256));
      end
      check("t6_wrap_pc", 64'(pc), 64'd256);
      check("t6_wrap_acc", 64'(acc_out), 64'd0);
      run = 1'b0;

      // ena=0 for 5 cycles mid-WAIT freezes the timeout
      do_reset();
      romlen = 1;
      rom[0] = 8'h03;
      lat_tab[0] = 0;
      run = 1'b1;
      wait_state(3'd3);
      n = 0;
      repeat (3) begin
         @(negedge clock);
         n++;
      end
      ena = 1'b0;
      @(negedge clock);
      n++;
      force_done = 1'b1;
      @(negedge clock);
      n++;
      force_done = 1'b0;
      repeat (3) begin
         @(negedge clock);
         n++;
      end
      check("t6_ena_state", 64'(state_out), 64'd3);
      check("t6_ena_err", 64'(error), 64'd0);
      ena = 1'b1;
      while (!halted && n < 60) begin
         @(negedge clock);
         n++;
      end
      check("t6_ena_to", 64'(n), 64'd20);
      check("t6_ena_err2", 64'(error), 64'd1);

      // random program with random ALU latency
      do_reset();
      romlen = 16;
      for (int i = 0; i < 16; i++)
         rom[i] = {3'($urandom_range(0, 6)), 5'($urandom)};
      lat_rand = 1'b1;
      run = 1'b1;
      exp_acc = 8'h00;
      for (int k = 0; k < 40; k++) begin
         ins = rom[k % 16];
         wait_retire(n);
         exp_acc = model(exp_acc, ins);
         if (ins[7:5] == 3'b110)
            exp_lat = 2;
         else if (lat_q.size() == 0)
            exp_lat = -1;
         else
            exp_lat = 3 + lat_q.pop_front();
         check("rnd_acc", 64'(acc_out), 64'(exp_acc));
         check("rnd_count", 64'(instr_count), 64'((k + 1) % 256));
         if (k > 0) check("rnd_lat", 64'(n), 64'(exp_lat));
      end
      run = 1'b0;
      repeat (10) @(negedge clock);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
